// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
//   state_t   : responder FSM states
//   req_t     : latched access (op, write data, error cause)
//   err_cause : classifies an incoming access into error-cause bits
package data_mem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;   // holds LATENCY-2 for LATENCY up to 15
  localparam int unsigned ERR_W  = 3;

  // Bit positions in the error-cause vector (debug visibility)
  localparam int unsigned ERR_MISALIGN = 0;
  localparam int unsigned ERR_RANGE    = 1;
  localparam int unsigned ERR_BOTH     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [WORD_W-1:0] wdata;
    logic [ERR_W-1:0]  cause;
  } req_t;

  // Misaligned, beyond the array (no wrap-around), or read and write together
  function automatic logic [ERR_W-1:0] err_cause(input logic [WORD_W-1:0] addr,
                                                 input logic              rd,
                                                 input logic              wr,
                                                 input int unsigned       depth);
    logic [ERR_W-1:0] c;
    c               = '0;
    c[ERR_MISALIGN] = (addr[1:0] != 2'b00);
    c[ERR_RANGE]    = (addr >= WORD_W'(depth * 32'd4));
    c[ERR_BOTH]     = rd & wr;
    return c;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Requester <-> responder data-memory bus.
//   master : memRead, memWrite, Address, writeData out; readData, ready, busy, err in
//   slave  : the reverse
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic              memRead;
  logic              memWrite;
  logic [WORD_W-1:0] Address;
  logic [WORD_W-1:0] writeData;
  logic [WORD_W-1:0] readData;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output memRead, memWrite, Address, writeData,
    input  readData, ready, busy, err
  );

  modport slave (
    input  memRead, memWrite, Address, writeData,
    output readData, ready, busy, err
  );

endinterface

// File: rtl/data_mem_array.sv
// Single-port word RAM, synchronous write, registered read.
//   i_clk   : clock
//   i_en    : access enable
//   i_we    : write (1) / read (0) when enabled
//   i_idx   : word index
//   i_wdata : write data
//   o_rdata : read data, updated only by an enabled read
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 i_clk,
  input  logic                 i_en,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_idx,
  input  logic [WORD_W-1:0]    i_wdata,
  output logic [WORD_W-1:0]    o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // Storage is never reset; read data holds between reads
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_idx] <= i_wdata;
      else      r_rdata      <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one access, waits LATENCY
// cycles, performs it on the edge entering DONE and pulses ready.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any transaction)
//   bus  : slave side of data_mem_responder_if
//          (memRead/memWrite/Address/writeData in; readData/ready/busy/err out)
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam bit               SINGLE   = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  req_t                 r_req, w_req_in, w_acc;
  logic [ADDR_BITS-1:0] r_idx, w_idx_in, w_acc_idx;
  logic                 w_req_valid;
  logic                 w_access;
  logic                 w_acc_err;
  logic                 w_ram_en, w_ram_we;
  logic [WORD_W-1:0]    w_ram_rdata;
  logic                 r_ready, r_busy, r_err, r_rd_sel;
  logic                 w_ready_nxt, w_busy_nxt, w_err_nxt, w_rd_sel_nxt;

  // Incoming request decode
  assign w_req_valid    = bus.memRead | bus.memWrite;
  assign w_idx_in       = bus.Address[ADDR_BITS+1:2];
  assign w_req_in.wr    = bus.memWrite;
  assign w_req_in.wdata = bus.writeData;
  assign w_req_in.cause = err_cause(bus.Address, bus.memRead, bus.memWrite, DEPTH);

  // State and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: IDLE -> WAIT (counting down) -> DONE, or IDLE -> DONE when LATENCY=1
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req_valid) begin
          if (SINGLE) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_DONE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs and RAM control. With LATENCY=1 the access happens on the accept
  // edge, so the live request is used in place of the not-yet-latched copy.
  always_comb begin
    w_acc        = r_req;
    w_acc_idx    = r_idx;
    if (r_state == ST_IDLE) begin
      w_acc     = w_req_in;
      w_acc_idx = w_idx_in;
    end
    w_access     = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
    w_acc_err    = |w_acc.cause;
    w_ram_en     = w_access & ~w_acc_err & ~rst;
    w_ram_we     = w_ram_en & w_acc.wr;
    w_ready_nxt  = w_access;
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    w_err_nxt    = w_access & w_acc_err;
    w_rd_sel_nxt = r_rd_sel;
    if (w_access) begin
      if (w_acc_err)       w_rd_sel_nxt = 1'b0;
      else if (!w_acc.wr)  w_rd_sel_nxt = 1'b1;
    end
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      r_ready  <= w_ready_nxt;
      r_busy   <= w_busy_nxt;
      r_err    <= w_err_nxt;
      r_rd_sel <= w_rd_sel_nxt;
    end
  end

  // Request latch; later input changes cannot affect the transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req <= '0;
      r_idx <= '0;
    end else if ((r_state == ST_IDLE) && w_req_valid) begin
      r_req <= w_req_in;
      r_idx <= w_idx_in;
    end
  end

  data_mem_array #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .i_clk   (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_idx   (w_acc_idx),
    .i_wdata (w_acc.wdata),
    .o_rdata (w_ram_rdata)
  );

  // RAM read register is not resettable, so zero is forced until the next good read
  assign bus.readData = r_rd_sel ? w_ram_rdata : '0;
  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder at LATENCY 2, 1 and 4.
module tb_data_mem_responder;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if if_l2();
  data_mem_responder_if if_l1();
  data_mem_responder_if if_l4();

  data_mem_responder #(.DEPTH(1024), .ADDR_BITS(10), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(if_l2));
  data_mem_responder #(.DEPTH(1024), .ADDR_BITS(10), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(if_l1));
  data_mem_responder #(.DEPTH(1024), .ADDR_BITS(10), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(if_l4));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    int          sel;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } stim_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [int];
  logic [31:0] model_rd  [3];
  int          checks = 0;
  int          errors = 0;

  function automatic int lat_of(input int sel);
    case (sel)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    case (sel)
      0: begin if_l2.memRead = rd; if_l2.memWrite = wr; if_l2.Address = addr; if_l2.writeData = wdata; end
      1: begin if_l1.memRead = rd; if_l1.memWrite = wr; if_l1.Address = addr; if_l1.writeData = wdata; end
      default: begin if_l4.memRead = rd; if_l4.memWrite = wr; if_l4.Address = addr; if_l4.writeData = wdata; end
    endcase
  endtask

  task automatic sample(input int sel, output logic rdy, output logic bsy,
                        output logic er, output logic [31:0] rdat);
    case (sel)
      0: begin rdy = if_l2.ready; bsy = if_l2.busy; er = if_l2.err; rdat = if_l2.readData; end
      1: begin rdy = if_l1.ready; bsy = if_l1.busy; er = if_l1.err; rdat = if_l1.readData; end
      default: begin rdy = if_l4.ready; bsy = if_l4.busy; er = if_l4.err; rdat = if_l4.readData; end
    endcase
  endtask

  // Reference behaviour: compute the expected completion and queue it
  function automatic void model_push(input int sel, input logic rd, input logic wr,
                                     input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   key;
    key = sel * 4096 + int'(addr[11:2]);
    if ((addr[1:0] != 2'b00) || (addr >= 32'h1000) || (rd && wr)) begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
    end else if (wr) begin
      model_mem[key] = wdata;
      e.rdata = model_rd[sel];
      e.err   = 1'b0;
    end else begin
      e.rdata = model_mem.exists(key) ? model_mem[key] : 32'hxxxxxxxx;
      e.err   = 1'b0;
    end
    model_rd[sel] = e.rdata;
    sb_q.push_back(e);
  endfunction

  // Issue one access from an IDLE cycle, hold it until ready (scrambling the
  // bus after accept), then spend one more cycle back in IDLE.
  task automatic do_txn(input stim_t s, output int lat, output logic bsy_ok,
                        output logic pulse_ok, output logic [31:0] rdat, output logic er);
    logic rdy, b, e;
    logic [31:0] d;
    model_push(s.sel, s.rd, s.wr, s.addr, s.wdata);
    drive(s.sel, s.rd, s.wr, s.addr, s.wdata);
    lat = -1; bsy_ok = 1'b1; pulse_ok = 1'b0; rdat = 32'h0; er = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(s.sel, s.rd, s.wr, s.addr ^ 32'h4, ~s.wdata);
      sample(s.sel, rdy, b, e, d);
      if (!b) bsy_ok = 1'b0;
      if (rdy) begin
        lat = c; rdat = d; er = e;
        break;
      end
    end
    drive(s.sel, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    sample(s.sel, rdy, b, e, d);
    pulse_ok = !rdy && !b;
  endtask

  task automatic test_reset();
    logic rdy, b, e;
    logic [31:0] d;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sample(s, rdy, b, e, d);
      checks++;
      if ({rdy, b, e, d} !== 35'h0) begin
        errors++;
        $display("FAIL reset dut%0d: ready=%b busy=%b err=%b readData=%h, want all 0", s, rdy, b, e, d);
      end
      model_rd[s] = 32'h0;
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    stim_t st[2];
    int lat; logic bok, pok, er; logic [31:0] rd;
    exp_t e;
    st[0] = '{sel: 0, rd: 1'b0, wr: 1'b1, addr: 32'h10, wdata: 32'hDEADBEEF};
    st[1] = '{sel: 0, rd: 1'b1, wr: 1'b0, addr: 32'h10, wdata: 32'h0};
    for (int i = 0; i < 2; i++) begin
      do_txn(st[i], lat, bok, pok, rd, er);
      e = sb_q.pop_front();
      checks++; if (lat !== 2) begin errors++; $display("FAIL wr_rd latency txn%0d: got %0d want 2", i, lat); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL wr_rd busy txn%0d: got low while pending, want high", i); end
      checks++; if (pok !== 1'b1) begin errors++; $display("FAIL wr_rd pulse txn%0d: ready/busy not low after DONE", i); end
      checks++; if (er !== e.err) begin errors++; $display("FAIL wr_rd err txn%0d: got %b want %b", i, er, e.err); end
      checks++; if (rd !== e.rdata) begin errors++; $display("FAIL wr_rd readData txn%0d: got %h want %h", i, rd, e.rdata); end
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd readback: got %h want deadbeef", rd); end
  endtask

  task automatic test_errors();
    stim_t st[10];
    int lat; logic bok, pok, er; logic [31:0] rd;
    exp_t e;
    st[0] = '{sel: 0, rd: 1'b1, wr: 1'b0, addr: 32'h12,   wdata: 32'h0};
    st[1] = '{sel: 0, rd: 1'b0, wr: 1'b1, addr: 32'h13,   wdata: 32'h12345678};
    st[2] = '{sel: 0, rd: 1'b1, wr: 1'b0, addr: 32'h10,   wdata: 32'h0};
    st[3] = '{sel: 0, rd: 1'b0, wr: 1'b1, addr: 32'h0,    wdata: 32'h0BADF00D};
    st[4] = '{sel: 0, rd: 1'b1, wr: 1'b0, addr: 32'h1000, wdata: 32'h0};
    st[5] = '{sel: 0, rd: 1'b0, wr: 1'b1, addr: 32'h1000, wdata: 32'hCAFEF00D};
    st[6] = '{sel: 0, rd: 1'b1, wr: 1'b0, addr: 32'h0,    wdata: 32'h0};
    st[7] = '{sel: 0, rd: 1'b0, wr: 1'b1, addr: 32'h20,   wdata: 32'h5555AAAA};
    st[8] = '{sel: 0, rd: 1'b1, wr: 1'b1, addr: 32'h20,   wdata: 32'hFFFFFFFF};
    st[9] = '{sel: 0, rd: 1'b1, wr: 1'b0, addr: 32'h20,   wdata: 32'h0};
    for (int i = 0; i < 10; i++) begin
      do_txn(st[i], lat, bok, pok, rd, er);
      e = sb_q.pop_front();
      checks++; if (lat !== 2) begin errors++; $display("FAIL errs latency txn%0d: got %0d want 2", i, lat); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL errs busy txn%0d: got low while pending, want high", i); end
      checks++; if (pok !== 1'b1) begin errors++; $display("FAIL errs pulse txn%0d: ready/busy not low after DONE", i); end
      checks++; if (er !== e.err) begin errors++; $display("FAIL errs err txn%0d: got %b want %b", i, er, e.err); end
      checks++; if (rd !== e.rdata) begin errors++; $display("FAIL errs readData txn%0d: got %h want %h", i, rd, e.rdata); end
    end
  endtask

  task automatic test_reset_abort();
    stim_t s;
    int lat, pulses; logic bok, pok, er; logic [31:0] rd;
    logic rdy, b, e;
    logic [31:0] d;
    exp_t ex;
    drive(0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5);
    @(posedge clk); #1;
    sample(0, rdy, b, e, d);
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL abort busy in WAIT: got %b want 1", b); end
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    sample(0, rdy, b, e, d);
    checks++;
    if ({rdy, b, e, d} !== 35'h0) begin
      errors++;
      $display("FAIL abort outputs: ready=%b busy=%b err=%b readData=%h, want all 0", rdy, b, e, d);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) model_rd[i] = 32'h0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      sample(0, rdy, b, e, d);
      if (rdy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort ready pulses: got %0d want 0", pulses); end
    s = '{sel: 0, rd: 1'b1, wr: 1'b0, addr: 32'h20, wdata: 32'h0};
    do_txn(s, lat, bok, pok, rd, er);
    ex = sb_q.pop_front();
    checks++; if (rd !== ex.rdata) begin errors++; $display("FAIL abort readback: got %h want %h", rd, ex.rdata); end
    checks++; if (rd !== 32'h5555AAAA) begin errors++; $display("FAIL abort old value: got %h want 5555aaaa", rd); end
  endtask

  task automatic test_back_to_back(input int sel);
    stim_t s;
    int lat, L, k, last, exp_at;
    logic bok, pok, er; logic [31:0] rd;
    logic rdy, b, e;
    logic [31:0] d;
    exp_t ex;
    L = lat_of(sel);
    for (int i = 0; i < 3; i++) begin
      s = '{sel: sel, rd: 1'b0, wr: 1'b1, addr: 32'h40 + 32'(4 * i),
            wdata: 32'hB0B00000 | 32'(sel << 8) | 32'(i)};
      do_txn(s, lat, bok, pok, rd, er);
      ex = sb_q.pop_front();
      checks++; if (lat !== L) begin errors++; $display("FAIL b2b%0d prewrite latency %0d: got %0d want %0d", sel, i, lat, L); end
      checks++; if (er !== ex.err) begin errors++; $display("FAIL b2b%0d prewrite err %0d: got %b want %b", sel, i, er, ex.err); end
    end
    for (int i = 0; i < 3; i++) model_push(sel, 1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'h0);
    drive(sel, 1'b1, 1'b0, 32'h40, 32'h0);
    k = 0; last = 0;
    for (int c = 1; c <= 3 * (L + 1) + 6; c++) begin
      @(posedge clk); #1;
      sample(sel, rdy, b, e, d);
      if (rdy) begin
        exp_at = (k == 0) ? L : last + L + 1;
        checks++; if (c !== exp_at) begin errors++; $display("FAIL b2b%0d ready cycle rd%0d: got %0d want %0d", sel, k, c, exp_at); end
        if (sb_q.size() > 0) begin
          ex = sb_q.pop_front();
          checks++; if (d !== ex.rdata) begin errors++; $display("FAIL b2b%0d readData rd%0d: got %h want %h", sel, k, d, ex.rdata); end
          checks++; if (e !== ex.err) begin errors++; $display("FAIL b2b%0d err rd%0d: got %b want %b", sel, k, e, ex.err); end
        end
        last = c;
        k++;
        if (k < 3) drive(sel, 1'b1, 1'b0, 32'h40 + 32'(4 * k), 32'h0);
        else       drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    checks++; if (k !== 3) begin errors++; $display("FAIL b2b%0d ready count: got %0d want 3", sel, k); end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    while (sb_q.size() > 0) void'(sb_q.pop_front());
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_reset_abort();
    test_back_to_back(1);
    test_back_to_back(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
